fsub_seq_ctrl: RTL



---
 rtl/fsub_seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fsub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fsub_seq_ctrl
// Multi-cycle wide subtractor. One fsub_4b nibble subtractor is reused
// NIBBLES times, least-significant nibble first. The borrow is chained
// through a register between nibbles. The result and the final borrow are
// published together with a one-cycle DONE pulse.
//
// Optional build macro:
//   FSUB_SEQ_SAT_EN - saturating mode. When the final borrow is 1, DIFF
//                     loads zero instead of the wrapped difference.
//                     BOUT still reports the borrow.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// 4-bit subtractor: SUM = A - B - CIN mod 16, BORROW = (A < B + CIN)
module fsub_4b (
    output logic [3:0] SUM,
    output logic       BORROW,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN
);
    logic [4:0] diff5_s;

    // 5-bit subtraction; bit 4 is set exactly when the result went negative
    always_comb begin
        diff5_s = {1'b0, A} - {1'b0, B} - {4'b0000, CIN};
    end

    assign SUM    = diff5_s[3:0];
    assign BORROW = diff5_s[4];
endmodule

module fsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   BIN,
    output logic                   READY,
    output logic [4*NIBBLES-1:0]   DIFF,
    output logic                   BOUT,
    output logic                   DONE
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Registered state and datapath
    logic [1:0]    state_q,  state_d;
    logic [W-1:0]  a_q,      a_d;      // latched minuend, shifted right per nibble
    logic [W-1:0]  b_q,      b_d;      // latched subtrahend, shifted right per nibble
    logic [W-1:0]  acc_q,    acc_d;    // result accumulator, filled from the top
    logic          borrow_q, borrow_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [W-1:0]  diff_q,   diff_d;
    logic          bout_q,   bout_d;
    logic          ready_q,  ready_d;
    logic          done_q,   done_d;

    // Nibble subtractor I/O; inputs come straight from register bits
    logic [3:0] nib_sum_s;
    logic       nib_borrow_s;

    // Shifting the operands keeps the active nibble in bits [3:0], so the
    // subtractor sees register outputs with no index multiplexer in front.
    fsub_4b u_fsub_4b (nib_sum_s, nib_borrow_s, a_q[3:0], b_q[3:0], borrow_q);

    // Next-state and datapath decode for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_RUN;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = BIN;
                    acc_d    = {W{1'b0}};
                    idx_d    = {IW{1'b0}};
                    ready_d  = 1'b0;
                end else begin
                    ready_d  = 1'b1;
                end
            end
            ST_RUN: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                acc_d    = (acc_q >> 4) | (W'(nib_sum_s) << (W - 4));
                borrow_d = nib_borrow_s;
                idx_d    = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bout_d  = nib_borrow_s;
`ifdef FSUB_SEQ_SAT_EN
                    if (nib_borrow_s) begin
                        diff_d = {W{1'b0}};
                    end else begin
                        diff_d = acc_d;
                    end
`else
                    diff_d = acc_d;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            acc_q    <= {W{1'b0}};
            borrow_q <= 1'b0;
            idx_q    <= {IW{1'b0}};
            diff_q   <= {W{1'b0}};
            bout_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign READY = ready_q;
    assign DONE  = done_q;
    assign DIFF  = diff_q;
    assign BOUT  = bout_q;
endmodule
